// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory,
// and presents each fetched word to decode over a valid/ready handshake.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [31:0]        ir_instr,
    output logic [31:0]        ir_pc,
    output logic [31:0]        ir_pc_plus4,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_FLUSH,
        ST_FAULT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_bad;
    logic        slot_free;
    logic        do_load;
    logic        do_redirect;
    logic        go_fault;

    assign imem_addr = pc[IMEM_AW-1:0];
    assign pc_plus4  = pc + 32'd4;
    assign slot_free = !ir_valid || ir_ready;

    // Misaligned, or beyond the instruction memory; caught before pc+4 can wrap.
    assign pc_bad = (pc[1:0] != 2'b00) || (pc[31:IMEM_AW] != '0);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        do_load     = 1'b0;
        do_redirect = 1'b0;
        go_fault    = 1'b0;
        case (state)
            ST_START, ST_FLUSH: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                    state_next  = ST_FLUSH;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                    state_next  = ST_FLUSH;
                end else if (slot_free) begin
                    if (pc_bad) begin
                        go_fault   = 1'b1;
                        state_next = ST_FAULT;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_START;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_START;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ir_valid    <= 1'b0;
            ir_instr    <= 32'h0;
            ir_pc       <= 32'h0;
            ir_pc_plus4 <= 32'h0;
            fetch_fault <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            // A handshake in the same cycle as a redirect still counts.
            if (ir_valid && ir_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (do_redirect) begin
                pc       <= redirect_pc;
                ir_valid <= 1'b0;
            end else if (do_load) begin
                ir_instr    <= imem_rdata;
                ir_pc       <= pc;
                ir_pc_plus4 <= pc_plus4;
                ir_valid    <= 1'b1;
                pc          <= pc_plus4;
            end else if (go_fault) begin
                ir_valid    <= 1'b0;
                fetch_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: small program in a combinational memory model,
// hand-computed expectations for pc sequencing, backpressure, redirects and faults.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_instr;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[13:2]];

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (14)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_instr       (ir_instr),
        .ir_pc          (ir_pc),
        .ir_pc_plus4    (ir_pc_plus4),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Program 0x00..0xa4 with addi x0,x0,<index>, then the named words.
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i <= 41; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[0]  = 32'hffe1_8113;
        mem[1]  = 32'hfff1_8a13;
        mem[2]  = 32'h0031_8a93;
        mem[40] = 32'h0021_8293;

        rst            = 1'b1;
        ir_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick(2);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_instr", ir_instr, 32'h0);
        check("rst_pc", ir_pc, 32'h0);
        check("rst_pc4", ir_pc_plus4, 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h0);

        rst = 1'b0;
        tick();
        check("start_bubble", 32'(ir_valid), 32'd0);
        tick();
        check("first_valid", 32'(ir_valid), 32'd1);
        check("first_pc", ir_pc, 32'h0);
        check("first_instr", ir_instr, 32'hffe1_8113);
        check("first_count", fetch_count, 32'd0);
        tick();
        check("second_pc", ir_pc, 32'h4);
        check("second_instr", ir_instr, 32'hfff1_8a13);
        check("second_pc4", ir_pc_plus4, 32'h8);
        check("second_count", fetch_count, 32'd1);
        tick();
        check("third_pc", ir_pc, 32'h8);
        check("third_count", fetch_count, 32'd2);

        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_instr", ir_instr, 32'h0031_8a93);
            check("bp_addr", 32'(imem_addr), 32'h0c);
            check("bp_count", fetch_count, 32'd2);
            check("bp_valid", 32'(ir_valid), 32'd1);
        end
        ir_ready = 1'b1;
        tick();
        check("bp_release_pc", ir_pc, 32'h0c);
        check("bp_release_count", fetch_count, 32'd3);

        tick(27);
        check("run_pc_78", ir_pc, 32'h78);
        check("run_instr_78", ir_instr, 32'h01e0_0013);
        check("run_count_78", fetch_count, 32'd30);

        redirect_valid = 1'b1;
        redirect_pc    = 32'ha0;
        tick();
        redirect_valid = 1'b0;
        check("redir_count", fetch_count, 32'd31);
        check("redir_flush_valid", 32'(ir_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'ha0);
        tick();
        check("redir_bubble2", 32'(ir_valid), 32'd0);
        tick();
        check("redir_valid", 32'(ir_valid), 32'd1);
        check("redir_pc", ir_pc, 32'ha0);
        check("redir_instr", ir_instr, 32'h0021_8293);

        tick(2);
        check("zero_pc", ir_pc, 32'ha8);
        check("zero_instr", ir_instr, 32'h0);
        check("zero_valid", 32'(ir_valid), 32'd1);
        check("zero_fault", 32'(fetch_fault), 32'd0);
        check("zero_count", fetch_count, 32'd33);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h62;
        tick();
        redirect_valid = 1'b0;
        check("mis_flush_valid", 32'(ir_valid), 32'd0);
        check("mis_flush_fault", 32'(fetch_fault), 32'd0);
        tick();
        check("mis_run_fault", 32'(fetch_fault), 32'd0);
        tick();
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_valid", 32'(ir_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick(2);
        redirect_valid = 1'b0;
        check("fault_ign_fault", 32'(fetch_fault), 32'd1);
        check("fault_ign_valid", 32'(ir_valid), 32'd0);
        check("fault_ign_addr", 32'(imem_addr), 32'h62);
        check("fault_ign_count", fetch_count, 32'd34);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("clr_fault", 32'(fetch_fault), 32'd0);
        check("clr_count", fetch_count, 32'd0);
        check("clr_addr", 32'(imem_addr), 32'h0);
        tick(2);
        check("restart_valid", 32'(ir_valid), 32'd1);
        check("restart_pc", ir_pc, 32'h0);

        // Last in-range word loads; the following pc (0x4000) must fault.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3ffc;
        tick();
        redirect_valid = 1'b0;
        tick(2);
        check("edge_valid", 32'(ir_valid), 32'd1);
        check("edge_pc", ir_pc, 32'h3ffc);
        check("edge_pc4", ir_pc_plus4, 32'h4000);
        check("edge_fault", 32'(fetch_fault), 32'd0);
        tick();
        check("edge_over_fault", 32'(fetch_fault), 32'd1);
        check("edge_over_valid", 32'(ir_valid), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000;
        tick();
        redirect_valid = 1'b0;
        tick(2);
        check("oor_fault", 32'(fetch_fault), 32'd1);
        check("oor_valid", 32'(ir_valid), 32'd0);

        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        check("rstred_valid", 32'(ir_valid), 32'd0);
        check("rstred_fault", 32'(fetch_fault), 32'd0);
        check("rstred_count", fetch_count, 32'd0);
        check("rstred_addr", 32'(imem_addr), 32'h0);
        tick(2);
        check("rstred_pc", ir_pc, 32'h0);
        check("rstred_instr", ir_instr, 32'hffe1_8113);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
